nano_ctrl: RTL and testbench
============================

Name: nano_ctrl

Overview:
- Control unit that drives the 8-bit ALU (op/A/B in, result out) of the Nano datapath.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them.
- Issues one ALU operation per instruction and writes the result back to an accumulator.
- Holds a 4-entry register file and a zero flag, and supports jumps and halt.

Parameters:
- PC_W, 8, program-counter and instruction-address width; PC wraps modulo 2^PC_W.
- NREG, 4, number of 8-bit general registers (index field is 2 bits; fixed at 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts execution from IDLE or HALT.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_ack  in  1  instruction valid on imem_data this cycle.
- imem_data  in  16  instruction word.
- alu_op  out  3  ALU opcode.
- alu_a  out  8  ALU port A.
- alu_b  out  8  ALU port B.
- alu_res  in  8  ALU result; combinational from alu_op/alu_a/alu_b.
- acc  out  8  accumulator.
- zero  out  1  Z flag.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an instruction selects ALU op 3'b111.

Behaviour:
- Reset (asynchronous, immediate):
  - State=IDLE; PC, acc, all registers, zero, illegal and halted = 0.
  - imem_req=0, alu_op=000, alu_a=0, alu_b=0.
- Instruction word fields: [15:13] cls, [12:10] aop, [9:8] ridx, [7:0] imm.
- cls encodings:
  - 000 NOP.
  - 001 LDI: acc<=imm.
  - 010 ALUI: acc<=ALU(aop, acc, imm).
  - 011 ALUR: acc<=ALU(aop, acc, R[ridx]).
  - 100 STR: R[ridx]<=acc.
  - 101 JMP: PC<=imm[PC_W-1:0].
  - 110 JZ: PC<=imm if zero, else PC+1.
  - 111 HALT.
- ALU op codes: 000 pass A, 001 A+B, 010 A&B, 011 A|B, 100 A-B, 101 -A, 110 ~A.
  - All arithmetic is 8-bit modulo 2^8; no carry is kept.
  - aop=111 makes the ALU hold its previous output, so the controller never issues it: op is driven as 000, acc/zero are unchanged, illegal<=1, PC advances.
- zero <= (new acc==0), updated only by LDI, ALUI and ALUR; every other class leaves it unchanged.
- FSM:
  - IDLE: outputs idle. start -> FETCH.
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack, latch imem_data into the instruction register -> EXEC. Without ack, stay in FETCH with req held and addr stable.
  - EXEC (exactly 1 cycle): alu_op/alu_a/alu_b are driven combinationally from the instruction register, acc and R. At the clock edge, commit the write-back and update PC (PC+1 unless a jump is taken). Next state is FETCH, or HALT for cls=111.
  - HALT: halted=1, PC frozen. start -> PC<=0, halted<=0, go to FETCH. acc, R, zero and illegal are retained.
- ALU ports outside EXEC are op=000, a=0, b=0. ALU ports are valid only in EXEC.
- Throughput: 2 cycles per instruction with zero-wait ack; each extra wait cycle adds 1.
- imem_req deasserts the cycle after ack, because the state leaves FETCH.
- start is ignored while busy. imem_ack is ignored outside FETCH.
- PC wraps from 2^PC_W-1 to 0.
- A reset asserted mid-FETCH or mid-EXEC drops imem_req immediately and discards the instruction; no partial write-back occurs.

Decomposition:
- Package nano_pkg holds:
  - cls codes and ALU op codes (ALU_PASS..ALU_NOT, ALU_RSVD=3'b111);
  - instruction field bit positions;
  - the FSM state encoding.
- One natural sub-module, nano_regfile: 4x8 registers, one write port and one async read port, reset to 0.
- The ALU itself is instantiated at the top level, outside nano_ctrl.

Test Plan:
1. Program 0x2005 (LDI 5), 0x4403 (ALUI add 3), 0xE000, zero-wait ack, start pulse -> acc=0x08, zero=0, halted=1. Each instruction takes 2 cycles; alu_op=001, a=5, b=3 in the second EXEC.
2. Program 0x20FF, 0x4401, 0xC010 (JZ 0x10) -> acc=0x00, zero=1, next imem_addr=0x10. Also 0x2003, 0x5005 (sub 5) -> acc=0xFE, zero=0.
3. Program 0x2007, 0x8200 (STR R2), 0x2001, 0x6600 (ALUR add R2) -> acc=0x08; R2=0x07 unchanged by later ops.
4. Program 0x2009 then 0x5C00 (aop 111) -> illegal=1, acc=0x09, zero=0, alu_op=000 during that EXEC, PC advances.
5. Delay imem_ack by 3 cycles -> imem_req high and imem_addr stable for 4 cycles, instruction captured on the ack cycle only. A pulse on start during the wait is ignored.
6. Assert rst_n=0 mid-FETCH after a JMP 0x20 -> imem_req=0 immediately; PC, acc and state cleared. After release, start fetches from address 0.

Source files
------------

// File: rtl/nano_pkg.sv
// ----------------------------------------------------------------------------
// nano_pkg : shared encodings for the Nano controller            rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nano_pkg;

  localparam logic [2:0] CLS_NOP  = 3'b000;
  localparam logic [2:0] CLS_LDI  = 3'b001;
  localparam logic [2:0] CLS_ALUI = 3'b010;
  localparam logic [2:0] CLS_ALUR = 3'b011;
  localparam logic [2:0] CLS_STR  = 3'b100;
  localparam logic [2:0] CLS_JMP  = 3'b101;
  localparam logic [2:0] CLS_JZ   = 3'b110;
  localparam logic [2:0] CLS_HALT = 3'b111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_NEG  = 3'b101;
  localparam logic [2:0] ALU_NOT  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  localparam int CLS_MSB  = 15;
  localparam int CLS_LSB  = 13;
  localparam int AOP_MSB  = 12;
  localparam int AOP_LSB  = 10;
  localparam int RIDX_MSB = 9;
  localparam int RIDX_LSB = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nano_regfile.sv
// ----------------------------------------------------------------------------
// nano_regfile : 4x8 register file, one write port, async read    rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nano_regfile #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] regs [NREG];

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[i] <= 8'h00;
        end else if (we && waddr == 2'(i)) begin
          regs[i] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = regs[raddr];

endmodule

`default_nettype wire

// File: rtl/nano_ctrl.sv
// ----------------------------------------------------------------------------
// nano_ctrl : fetch/decode/execute controller for the Nano ALU    rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nano_ctrl
  import nano_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [2:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_res,
  output logic [7:0]      acc,
  output logic            zero,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_t          state;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc;

  logic [2:0] cls;
  logic [2:0] aop;
  logic [1:0] ridx;
  logic [7:0] imm;
  logic [7:0] rdata;
  logic       exec_alu;
  logic       aop_rsvd;
  logic       reg_we;

  assign cls  = ir[CLS_MSB:CLS_LSB];
  assign aop  = ir[AOP_MSB:AOP_LSB];
  assign ridx = ir[RIDX_MSB:RIDX_LSB];
  assign imm  = ir[IMM_MSB:IMM_LSB];

  assign exec_alu = (state == ST_EXEC) && (cls == CLS_ALUI || cls == CLS_ALUR);
  assign aop_rsvd = (aop == ALU_RSVD);
  assign reg_we   = (state == ST_EXEC) && (cls == CLS_STR);

  // The ALU would hold its previous output on the reserved op, so mask it to PASS.
  assign alu_op = (exec_alu && !aop_rsvd) ? aop : ALU_PASS;
  assign alu_a  = exec_alu ? acc : 8'h00;
  assign alu_b  = exec_alu ? ((cls == CLS_ALUR) ? rdata : imm) : 8'h00;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
  assign halted    = (state == ST_HALT);

  nano_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (reg_we),
    .waddr (ridx),
    .wdata (acc),
    .raddr (ridx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ir      <= 16'h0000;
      pc      <= '0;
      acc     <= 8'h00;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= (cls == CLS_HALT) ? ST_HALT : ST_FETCH;
          pc    <= pc + 1'b1;
          case (cls)
            CLS_LDI: begin
              acc  <= imm;
              zero <= (imm == 8'h00);
            end
            CLS_ALUI, CLS_ALUR: begin
              if (aop_rsvd) begin
                illegal <= 1'b1;
              end else begin
                acc  <= alu_res;
                zero <= (alu_res == 8'h00);
              end
            end
            CLS_JMP: pc <= imm[PC_W-1:0];
            CLS_JZ:  if (zero) pc <= imm[PC_W-1:0];
            default: ;
          endcase
        end
        ST_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nano_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nano_ctrl : scoreboard bench for nano_ctrl with a behavioural ALU/imem  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nano_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'hE0FF;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_res;
  logic [7:0]  acc;
  logic        zero;
  logic        busy;
  logic        halted;
  logic        illegal;

  always #5 clk = ~clk;

  nano_ctrl #(.PC_W(8), .NREG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .acc       (acc),
    .zero      (zero),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a - b;
      3'b101:  return 8'h00 - a;
      3'b110:  return ~a;
      default: return a;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] acc;
    logic       zero;
    logic       ill;
    logic       halt;
    logic [7:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fetch_log[$];
  logic [15:0] mem [256];

  logic [7:0] m_acc, m_pc;
  logic       m_zero, m_ill, m_halt;
  logic [7:0] m_r [4];

  int         ack_delay = 0;
  int         wait_cnt = 0;
  int         req_cycles = 0;
  logic [7:0] held_addr;
  logic       pending = 1'b0;
  exp_t       cur;

  function automatic void model_clear();
    m_acc = 8'h00; m_pc = 8'h00; m_zero = 1'b0; m_ill = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endfunction

  // Reference execution of one instruction; pushes the EXEC-time and post-commit expectations.
  function automatic void model_step(input logic [15:0] d);
    exp_t       e;
    logic [2:0] c   = d[15:13];
    logic [2:0] aop = d[12:10];
    logic [1:0] ri  = d[9:8];
    logic [7:0] im  = d[7:0];
    logic [7:0] nxt = m_pc + 8'd1;
    e.op = 3'b000; e.a = 8'h00; e.b = 8'h00;
    case (c)
      3'b001: begin m_acc = im; m_zero = (im == 8'h00); end
      3'b010, 3'b011: begin
        e.a = m_acc;
        e.b = (c == 3'b011) ? m_r[ri] : im;
        if (aop == 3'b111) m_ill = 1'b1;
        else begin
          e.op   = aop;
          m_acc  = alu_f(aop, e.a, e.b);
          m_zero = (m_acc == 8'h00);
        end
      end
      3'b100: m_r[ri] = m_acc;
      3'b101: nxt = im;
      3'b110: if (m_zero) nxt = im;
      3'b111: m_halt = 1'b1;
      default: ;
    endcase
    m_pc   = nxt;
    e.acc  = m_acc; e.zero = m_zero; e.ill = m_ill; e.halt = m_halt; e.pc = m_pc;
    sb.push_back(e);
  endfunction

  // Instruction memory responder with programmable ack latency.
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack  = 1'b0;
      imem_data = 16'hE0FF;
      wait_cnt  = 0;
    end else begin
      if (wait_cnt == 0) held_addr = imem_addr;
      else check_eq("addr_stable", imem_addr, held_addr);
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_data  = mem[imem_addr];
        req_cycles = wait_cnt + 1;
        fetch_log.push_back(imem_addr);
        check_eq("fetch_addr", imem_addr, m_pc);
        model_step(mem[imem_addr]);
        wait_cnt = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'hE0FF;
        wait_cnt++;
      end
    end
  end

  // EXEC is the only busy cycle without a fetch request.
  always @(negedge clk) begin
    if (pending) begin
      pending = 1'b0;
      check_eq("acc",     acc,       cur.acc);
      check_eq("zero",    zero,      cur.zero);
      check_eq("illegal", illegal,   cur.ill);
      check_eq("halted",  halted,    cur.halt);
      check_eq("next_pc", imem_addr, cur.pc);
    end
    if (rst_n && busy && !imem_req) begin
      if (sb.size() == 0) begin
        check_eq("sb_empty", 1, 0);
      end else begin
        cur = sb.pop_front();
        check_eq("alu_op", alu_op, cur.op);
        check_eq("alu_a",  alu_a,  cur.a);
        check_eq("alu_b",  alu_b,  cur.b);
        pending = 1'b1;
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    sb.delete();
    fetch_log.delete();
    pending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_prog(output int cyc);
    m_pc   = 8'h00;
    m_halt = 1'b0;
    fetch_log.delete();
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (halted) break;
      if (cyc >= 200) begin
        check_eq("halt_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int k;

    // Reset state
    fill_mem();
    do_reset();
    check_eq("rst_req",    imem_req, 0);
    check_eq("rst_addr",   imem_addr, 0);
    check_eq("rst_acc",    acc, 0);
    check_eq("rst_zero",   zero, 0);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_ill",    illegal, 0);
    check_eq("rst_alu",    {alu_op, alu_a, alu_b}, 0);

    // 1: LDI / ALUI add / HALT, zero-wait
    mem[0] = 16'h2005; mem[1] = 16'h4403; mem[2] = 16'hE000;
    run_prog(cyc);
    check_eq("t1_cycles", cyc, 7);
    check_eq("t1_acc",    acc, 8'h08);
    check_eq("t1_zero",   zero, 0);
    check_eq("t1_halted", halted, 1);

    // 2: zero flag, taken JZ, subtract wrap
    do_reset(); fill_mem();
    mem[0] = 16'h20FF; mem[1] = 16'h4401; mem[2] = 16'hC010;
    mem[8'h10] = 16'h2003; mem[8'h11] = 16'h5005; mem[8'h12] = 16'hE000;
    run_prog(cyc);
    check_eq("t2_jz_target", (fetch_log.size() > 3) ? fetch_log[3] : 8'hEE, 8'h10);
    check_eq("t2_acc",  acc, 8'hFE);
    check_eq("t2_zero", zero, 0);

    // 3: STR / ALUR, then restart from HALT keeping acc and R
    do_reset(); fill_mem();
    mem[0] = 16'h2007; mem[1] = 16'h8200; mem[2] = 16'h2001; mem[3] = 16'h6600;
    run_prog(cyc);
    check_eq("t3_acc", acc, 8'h08);
    fill_mem();
    mem[0] = 16'h6600;
    run_prog(cyc);
    check_eq("t3_restart_addr", (fetch_log.size() > 0) ? fetch_log[0] : 8'hEE, 8'h00);
    check_eq("t3_acc_retained", acc, 8'h0F);

    // 4: reserved ALU op
    do_reset(); fill_mem();
    mem[0] = 16'h2009; mem[1] = 16'h5C00;
    run_prog(cyc);
    check_eq("t4_illegal", illegal, 1);
    check_eq("t4_acc",     acc, 8'h09);
    check_eq("t4_zero",    zero, 0);
    check_eq("t4_pc_adv",  (fetch_log.size() > 2) ? fetch_log[2] : 8'hEE, 8'h02);

    // 5: three wait cycles per fetch, stray start pulse while busy
    do_reset(); fill_mem();
    mem[0] = 16'h2005; mem[1] = 16'h4403;
    ack_delay = 3;
    fork
      run_prog(cyc);
      begin
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_eq("t5_cycles",     cyc, 16);
    check_eq("t5_req_cycles", req_cycles, 4);
    check_eq("t5_acc",        acc, 8'h08);

    // 6: reset while fetching after a jump
    do_reset(); fill_mem();
    mem[0] = 16'hA020; mem[8'h20] = 16'h2001;
    ack_delay = 6;
    m_pc = 8'h00; m_halt = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(imem_req && imem_addr == 8'h20) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_reached_jmp", (k < 50) ? 1 : 0, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_req_drop", imem_req, 0);
    check_eq("t6_busy",     busy, 0);
    check_eq("t6_pc",       imem_addr, 0);
    check_eq("t6_acc",      acc, 0);
    model_clear();
    sb.delete();
    pending = 1'b0;
    ack_delay = 0;
    fill_mem();
    mem[0] = 16'h2042;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(cyc);
    check_eq("t6_restart_addr", (fetch_log.size() > 0) ? fetch_log[0] : 8'hEE, 8'h00);
    check_eq("t6_acc",          acc, 8'h42);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
